// File: rtl/pipe_sel_mux_buf.sv
// N-source select mux (one code selects a constant) feeding a registered
// 2-entry valid/ready elastic buffer with synchronous flush and a sticky bad-select flag.
module pipe_sel_mux_buf #(
  parameter int          WIDTH     = 32,
  parameter int          NUM_SRC   = 4,
  parameter int          SEL_W     = $clog2(NUM_SRC + 1),
  parameter int unsigned CONST_VAL = 0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [SEL_W-1:0]         in_sel,
  input  logic [NUM_SRC*WIDTH-1:0] in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [WIDTH-1:0]         out_data,
  output logic [SEL_W-1:0]         out_sel,
  output logic                     err,
  input  logic                     err_clr
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } state_t;

  localparam logic [SEL_W-1:0] CONST_CODE = SEL_W'(NUM_SRC);

  function automatic logic [WIDTH-1:0] sel_src(input logic [SEL_W-1:0]         s,
                                               input logic [NUM_SRC*WIDTH-1:0] d);
    logic [WIDTH-1:0] r;
    r = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      if (s == SEL_W'(k)) r = d[k*WIDTH +: WIDTH];
    end
    if (s == CONST_CODE) r = WIDTH'(CONST_VAL);
    return r;
  endfunction

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sel_data_p0;
  logic               bad_sel_p0;
  logic [WIDTH-1:0]   main_data_p1, skid_data_p1;
  logic [SEL_W-1:0]   main_sel_p1, skid_sel_p1;
  logic               err_q;
  logic               accept, deliver;
  logic               load_main, load_skid, move_skid;

  // Stage p0: combinational source select
  assign sel_data_p0 = sel_src(in_sel, in_data);
  assign bad_sel_p0  = (in_sel > CONST_CODE);

  // Handshake flags come straight from the state register, so in_ready never sees out_ready
  assign in_ready  = (state_q != FULL);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready & ~flush;
  assign deliver   = out_valid & out_ready;

  always_comb begin
    state_d   = state_q;
    load_main = 1'b0;
    load_skid = 1'b0;
    move_skid = 1'b0;
    case (state_q)
      EMPTY: begin
        if (accept) begin
          state_d   = ONE;
          load_main = 1'b1;
        end
      end
      ONE: begin
        if (accept && deliver) begin
          load_main = 1'b1;
        end else if (accept) begin
          state_d   = FULL;
          load_skid = 1'b1;
        end else if (deliver) begin
          state_d = EMPTY;
        end
      end
      FULL: begin
        if (deliver) begin
          state_d   = ONE;
          move_skid = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    // Flush drops everything buffered plus any beat offered this cycle
    if (flush) begin
      state_d   = EMPTY;
      load_main = 1'b0;
      load_skid = 1'b0;
      move_skid = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= EMPTY;
    else        state_q <= state_d;
  end

  // Stage p1: main (output) and skid registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      main_data_p1 <= '0;
      main_sel_p1  <= '0;
      skid_data_p1 <= '0;
      skid_sel_p1  <= '0;
    end else begin
      if (load_main) begin
        main_data_p1 <= sel_data_p0;
        main_sel_p1  <= in_sel;
      end else if (move_skid) begin
        main_data_p1 <= skid_data_p1;
        main_sel_p1  <= skid_sel_p1;
      end
      if (load_skid) begin
        skid_data_p1 <= sel_data_p0;
        skid_sel_p1  <= in_sel;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                    err_q <= 1'b0;
    else if (accept && bad_sel_p0) err_q <= 1'b1;
    else if (err_clr)              err_q <= 1'b0;
  end

  assign out_data = main_data_p1;
  assign out_sel  = main_sel_p1;
  assign err      = err_q;

endmodule

// File: tb/tb_pipe_sel_mux_buf.sv
// Bench for pipe_sel_mux_buf: directed scenarios plus a random stream, all
// checked against a queue-based capacity-2 FIFO model of the block.
module tb_pipe_sel_mux_buf;

  localparam int W  = 32;
  localparam int NS = 4;
  localparam int SW = 3;

  logic           clk = 1'b0;
  logic           rst_n;
  logic           flush;
  logic           in_valid;
  logic           in_ready;
  logic [SW-1:0]  in_sel;
  logic [NS*W-1:0] in_data;
  logic           out_valid;
  logic           out_ready;
  logic [W-1:0]   out_data;
  logic [SW-1:0]  out_sel;
  logic           err;
  logic           err_clr;

  pipe_sel_mux_buf #(.WIDTH(W), .NUM_SRC(NS), .CONST_VAL(31)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_sel(in_sel), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_sel(out_sel),
    .err(err), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0]  d;
    logic [SW-1:0] s;
  } beat_t;

  beat_t        q[$];
  logic [W-1:0] dlv[$];
  logic         err_m;
  int           n_assert = 0;
  int           n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] ref_sel(input logic [SW-1:0] s, input logic [NS*W-1:0] d);
    int k;
    k = int'(s);
    if (k < NS)       return d[k*W +: W];
    else if (k == NS) return 32'd31;
    else              return '0;
  endfunction

  // One clock of the model and the DUT, then compare every visible output
  task automatic cycle();
    bit    rdy, acc, del;
    beat_t b, h;
    rdy = (q.size() < 2);
    acc = in_valid && rdy && !flush;
    del = (q.size() > 0) && out_ready;
    b.d = ref_sel(in_sel, in_data);
    b.s = in_sel;
    @(posedge clk);
    #1;
    if (flush) q.delete();
    else begin
      if (del) begin
        h = q.pop_front();
        dlv.push_back(h.d);
      end
      if (acc) q.push_back(b);
    end
    if (acc && int'(in_sel) > NS) err_m = 1'b1;
    else if (err_clr)             err_m = 1'b0;
    chk("in_ready", in_ready, q.size() < 2);
    chk("out_valid", out_valid, q.size() > 0);
    if (q.size() > 0) begin
      chk("out_data", out_data, q[0].d);
      chk("out_sel", out_sel, q[0].s);
    end
    chk("err", err, err_m);
  endtask

  task automatic idle_drain(input int n);
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    err_clr   = 1'b0;
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    int idx;
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_sel = '0; in_data = '0;
    out_ready = 1'b0; err_clr = 1'b0; err_m = 1'b0;

    // Reset values
    #2;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_out_data", out_data, 32'h0);
    chk("rst_out_sel", out_sel, 3'd0);
    chk("rst_err", err, 1'b0);
    #10;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 1: source 2 with latency 1
    in_data = {$urandom, 32'hDEADBEEF, $urandom, $urandom};
    in_sel = 3'd2; in_valid = 1'b1; out_ready = 1'b1;
    cycle();
    chk("t1_data", out_data, 32'hDEADBEEF);
    chk("t1_sel", out_sel, 3'd2);

    // 2: constant code, bad code, err_clr colliding with a bad beat
    in_sel = 3'd4;
    cycle();
    chk("t2_const", out_data, 32'd31);
    in_sel = 3'd6;
    cycle();
    chk("t2_bad_data", out_data, 32'd0);
    chk("t2_err_set", err, 1'b1);
    in_sel = 3'd7; err_clr = 1'b1;
    cycle();
    chk("t2_set_wins", err, 1'b1);
    in_valid = 1'b0;
    cycle();
    chk("t2_err_clr", err, 1'b0);
    idle_drain(2);

    // 3: 8-beat stream with out_ready low in cycles 3-4
    dlv.delete();
    idx = 0;
    in_sel = 3'd0;
    for (int c = 0; c < 30 && (idx < 8 || q.size() > 0); c++) begin
      bit will_acc;
      in_valid  = (idx < 8);
      in_data   = {$urandom, $urandom, $urandom, 32'(idx + 1)};
      out_ready = !(c == 3 || c == 4);
      will_acc  = in_valid && (q.size() < 2);
      cycle();
      if (will_acc) idx++;
    end
    chk("t3_count", dlv.size(), 8);
    for (int i = 0; i < 8 && i < dlv.size(); i++) chk("t3_order", dlv[i], 32'(i + 1));
    idle_drain(1);

    // 4: flush while FULL with a beat offered
    out_ready = 1'b0; in_valid = 1'b1; in_sel = 3'd1;
    for (int i = 0; i < 2; i++) begin
      in_data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    chk("t4_full", in_ready, 1'b0);
    flush = 1'b1;
    cycle();
    chk("t4_flush_valid", out_valid, 1'b0);
    chk("t4_flush_ready", in_ready, 1'b1);
    flush = 1'b0;
    idle_drain(3);

    // 5: async reset while FULL with err set
    out_ready = 1'b0; in_valid = 1'b1;
    in_sel = 3'd5; in_data = {$urandom, $urandom, $urandom, $urandom};
    cycle();
    in_sel = 3'd3;
    cycle();
    chk("t5_err_pre", err, 1'b1);
    #3;
    rst_n = 1'b0;
    #1;
    q.delete(); err_m = 1'b0;
    chk("t5_out_valid", out_valid, 1'b0);
    chk("t5_out_data", out_data, 32'h0);
    chk("t5_err", err, 1'b0);
    chk("t5_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    #1;
    in_valid = 1'b1; out_ready = 1'b1; in_sel = 3'd1;
    in_data = {$urandom, $urandom, 32'hA5A5_0001, $urandom};
    cycle();
    chk("t5_latency1", out_data, 32'hA5A5_0001);
    idle_drain(2);

    // 6: 100 back-to-back random beats
    dlv.delete();
    in_valid = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      in_sel  = SW'($urandom_range(0, NS));
      in_data = {$urandom, $urandom, $urandom, $urandom};
      cycle();
    end
    idle_drain(1);
    chk("t6_count", dlv.size(), 100);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
